spi_slave_gen: RTL and testbench

SPI_SLAVE_GEN -- requirements
Module: spi_slave_gen

---
 rtl/spi_pkg.sv | 18 +
 rtl/spi_sync_edge.sv | 30 +++
 rtl/spi_slave_gen.sv | 184 ++++++++++++++++++
 tb/tb_spi_slave_gen.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave: FSM states, synchroniser depth and
// the helper that picks which SCLK edge samples MOSI for a given mode.
package spi_pkg;

  localparam int SYNC_DEPTH = 3;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } spi_state_t;

  // Leading edge is rising when CPOL=0; CPHA=0 samples on the leading edge.
  // Sampling therefore happens on the rising edge exactly when CPOL == CPHA.
  function automatic bit sample_is_rise(input bit cpol, input bit cpha);
    return !(cpol ^ cpha);
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Brings an asynchronous pin into the clk_in domain and produces registered
// one-cycle rise/fall pulses from the last two synchroniser stages.
module spi_sync_edge
  import spi_pkg::*;
#(
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic clk_in,
  input  logic rst,
  input  logic async_in,
  output logic rise,
  output logic fall
);

  logic [SYNC_DEPTH-1:0] sync_q;

  // Synchroniser chain preset to the idle level so reset never fakes an edge.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      sync_q <= {SYNC_DEPTH{IDLE_LEVEL}};
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_DEPTH-2:0], async_in};
      rise   <= sync_q[SYNC_DEPTH-2] & ~sync_q[SYNC_DEPTH-1];
      fall   <= ~sync_q[SYNC_DEPTH-2] & sync_q[SYNC_DEPTH-1];
    end
  end

endmodule

// File: rtl/spi_slave_gen.sv
// Oversampling SPI slave: all SPI pins are synchronised into clk_in and the
// protocol is run from detected SCLK/CS edges. Supports all four modes,
// either bit order, and back-to-back words inside one CS frame.
module spi_slave_gen
  import spi_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter bit CPOL      = 1'b1,
  parameter bit CPHA      = 1'b1,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              spi_sclk,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              rx_frame_err,
  output logic              tx_underrun,
  output logic              busy
);

  localparam bit SAMPLE_RISE = sample_is_rise(CPOL, CPHA);
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);

  spi_state_t state, state_next;

  logic sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic sample_edge, shift_edge;
  logic [SYNC_DEPTH-1:0] mosi_sync;
  logic mosi_s;

  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] hold_reg, tx_shift, rx_shift;
  logic [DATA_W-1:0] tx_load, tx_next, rx_next;
  logic hold_full, skip_shift, tx_fire;

  logic word_start, word_done, frame_end, frame_err, sample_evt, shift_evt;

  spi_sync_edge #(.IDLE_LEVEL(CPOL)) u_sclk_sync (
    .clk_in   (clk_in),
    .rst      (rst),
    .async_in (spi_sclk),
    .rise     (sclk_rise),
    .fall     (sclk_fall)
  );

  spi_sync_edge #(.IDLE_LEVEL(1'b1)) u_cs_sync (
    .clk_in   (clk_in),
    .rst      (rst),
    .async_in (spi_cs_n),
    .rise     (cs_rise),
    .fall     (cs_fall)
  );

  assign sample_edge = SAMPLE_RISE ? sclk_rise : sclk_fall;
  assign shift_edge  = SAMPLE_RISE ? sclk_fall : sclk_rise;
  assign mosi_s      = mosi_sync[SYNC_DEPTH-1];

  assign tx_load = hold_full ? hold_reg : '0;
  assign tx_next = MSB_FIRST ? {tx_shift[DATA_W-2:0], 1'b0} : {1'b0, tx_shift[DATA_W-1:1]};
  assign rx_next = MSB_FIRST ? {rx_shift[DATA_W-2:0], mosi_s} : {mosi_s, rx_shift[DATA_W-1:1]};
  assign tx_fire = tx_valid && !hold_full;

  assign tx_ready = !hold_full;
  assign busy     = (state == ST_ACTIVE);

  // MOSI goes through the same depth as SCLK so the sampled bit lines up with the detected edge.
  always_ff @(posedge clk_in) begin
    if (rst) mosi_sync <= '0;
    else     mosi_sync <= {mosi_sync[SYNC_DEPTH-2:0], spi_mosi};
  end

  // State register.
  always_ff @(posedge clk_in) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next state and per-cycle events; CS activity always wins over SCLK edges.
  always_comb begin
    state_next = state;
    word_start = 1'b0;
    word_done  = 1'b0;
    frame_end  = 1'b0;
    frame_err  = 1'b0;
    sample_evt = 1'b0;
    shift_evt  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cs_fall) begin
          state_next = ST_ACTIVE;
          word_start = 1'b1;
        end
      end
      ST_ACTIVE: begin
        word_done = (bit_cnt == CNT_FULL);
        if (cs_rise) begin
          state_next = ST_IDLE;
          frame_end  = 1'b1;
          frame_err  = (bit_cnt != '0) && !word_done;
        end else begin
          word_start = word_done;
          sample_evt = sample_edge && !word_done;
          shift_evt  = shift_edge && !word_done;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Shift registers, bit counter, holding register and the status pulses.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      bit_cnt      <= '0;
      hold_reg     <= '0;
      hold_full    <= 1'b0;
      tx_shift     <= '0;
      rx_shift     <= '0;
      skip_shift   <= 1'b0;
      spi_miso     <= 1'b0;
      spi_miso_oe  <= 1'b0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      tx_underrun  <= 1'b0;
    end else begin
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      tx_underrun  <= 1'b0;

      if (word_done) begin
        rx_data  <= rx_shift;
        rx_valid <= 1'b1;
        bit_cnt  <= '0;
      end

      if (frame_end) begin
        bit_cnt      <= '0;
        spi_miso     <= 1'b0;
        spi_miso_oe  <= 1'b0;
        rx_frame_err <= frame_err;
      end

      // On a mid-frame wrap the shift edge of the previous last bit is still
      // to come, so it must not advance past the freshly loaded first bit.
      if (word_start) begin
        tx_shift    <= tx_load;
        spi_miso    <= MSB_FIRST ? tx_load[DATA_W-1] : tx_load[0];
        tx_underrun <= !hold_full;
        hold_full   <= 1'b0;
        skip_shift  <= CPHA || (state == ST_ACTIVE);
        spi_miso_oe <= 1'b1;
      end

      if (sample_evt) begin
        rx_shift <= rx_next;
        bit_cnt  <= bit_cnt + CNT_W'(1);
      end

      if (shift_evt) begin
        if (skip_shift) begin
          skip_shift <= 1'b0;
        end else begin
          tx_shift <= tx_next;
          spi_miso <= MSB_FIRST ? tx_next[DATA_W-1] : tx_next[0];
        end
      end

      if (tx_fire) begin
        hold_reg  <= tx_data;
        hold_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_gen.sv
// Directed bench: three slave instances (mode 3/16-bit, mode 0/16-bit,
// mode 2/8-bit LSB-first) share SCLK/MOSI with separate chip selects, and a
// behavioural SPI master drives them from one initial block.
module tb_spi_slave_gen;

  localparam int HALF = 80;

  logic clk_in = 1'b0;
  logic rst;
  logic spi_sclk;
  logic spi_mosi;
  logic csN [3];
  logic miso [3];
  logic oe [3];
  logic txValid [3];
  logic txReady [3];
  logic rxValid [3];
  logic frameErr [3];
  logic underrun [3];
  logic busy [3];
  logic [15:0] tx16 [2];
  logic [15:0] rxData16 [2];
  logic [7:0]  tx8;
  logic [7:0]  rxData8;

  int total = 0;
  int bad = 0;
  int rxCount [3] = '{0, 0, 0};
  int errCount [3] = '{0, 0, 0};
  int urCount [3] = '{0, 0, 0};
  logic [15:0] rxLog [4];

  logic cpol, cpha, msbf;
  int width;

  always #5 clk_in = ~clk_in;

  spi_slave_gen #(.DATA_W(16), .CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b1)) dut_m3 (
    .clk_in(clk_in), .rst(rst), .spi_sclk(spi_sclk), .spi_cs_n(csN[0]), .spi_mosi(spi_mosi),
    .spi_miso(miso[0]), .spi_miso_oe(oe[0]), .tx_data(tx16[0]), .tx_valid(txValid[0]),
    .tx_ready(txReady[0]), .rx_data(rxData16[0]), .rx_valid(rxValid[0]),
    .rx_frame_err(frameErr[0]), .tx_underrun(underrun[0]), .busy(busy[0])
  );

  spi_slave_gen #(.DATA_W(16), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1)) dut_m0 (
    .clk_in(clk_in), .rst(rst), .spi_sclk(spi_sclk), .spi_cs_n(csN[1]), .spi_mosi(spi_mosi),
    .spi_miso(miso[1]), .spi_miso_oe(oe[1]), .tx_data(tx16[1]), .tx_valid(txValid[1]),
    .tx_ready(txReady[1]), .rx_data(rxData16[1]), .rx_valid(rxValid[1]),
    .rx_frame_err(frameErr[1]), .tx_underrun(underrun[1]), .busy(busy[1])
  );

  spi_slave_gen #(.DATA_W(8), .CPOL(1'b1), .CPHA(1'b0), .MSB_FIRST(1'b0)) dut_m8 (
    .clk_in(clk_in), .rst(rst), .spi_sclk(spi_sclk), .spi_cs_n(csN[2]), .spi_mosi(spi_mosi),
    .spi_miso(miso[2]), .spi_miso_oe(oe[2]), .tx_data(tx8), .tx_valid(txValid[2]),
    .tx_ready(txReady[2]), .rx_data(rxData8), .rx_valid(rxValid[2]),
    .rx_frame_err(frameErr[2]), .tx_underrun(underrun[2]), .busy(busy[2])
  );

  // Pulse counters sampled on the falling edge, away from DUT updates.
  always @(negedge clk_in) begin
    for (int k = 0; k < 3; k++) begin
      if (rxValid[k] === 1'b1) begin
        if (k == 1 && rxCount[1] < 4) rxLog[rxCount[1]] = rxData16[1];
        rxCount[k]++;
      end
      if (frameErr[k] === 1'b1) errCount[k]++;
      if (underrun[k] === 1'b1) urCount[k]++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic setMode(input logic p, input logic h, input logic m, input int w);
    cpol = p; cpha = h; msbf = m; width = w;
    spi_sclk = p;
    repeat (10) @(negedge clk_in);
  endtask

  task automatic pushTx(input int sel, input logic [15:0] d);
    int waited = 0;
    @(negedge clk_in);
    while (txReady[sel] !== 1'b1 && waited < 200) begin
      @(negedge clk_in);
      waited++;
    end
    checkOutput("tx_ready_wait", 32'(txReady[sel]), 32'h1);
    if (sel == 2) tx8 = d[7:0];
    else tx16[sel] = d;
    txValid[sel] = 1'b1;
    @(negedge clk_in);
    txValid[sel] = 1'b0;
  endtask

  task automatic csLow(input int sel);
    @(negedge clk_in);
    csN[sel] = 1'b0;
    #(HALF);
  endtask

  task automatic csHigh(input int sel);
    #(HALF);
    csN[sel] = 1'b1;
    repeat (10) @(negedge clk_in);
  endtask

  // Master side of one word (or a partial word of nbits bits).
  task automatic applyStimulus(input int sel, input int nbits, input logic [31:0] txw,
                               output logic [31:0] rxw);
    rxw = '0;
    for (int i = 0; i < nbits; i++) begin
      int idx;
      idx = msbf ? (width - 1 - i) : i;
      if (!cpha) begin
        spi_mosi = txw[idx];
        #(HALF);
        spi_sclk = ~cpol;
        rxw[idx] = miso[sel];
        #(HALF);
        spi_sclk = cpol;
      end else begin
        #(HALF);
        spi_sclk = ~cpol;
        spi_mosi = txw[idx];
        #(HALF);
        spi_sclk = cpol;
        rxw[idx] = miso[sel];
      end
    end
  endtask

  initial begin
    logic [31:0] rd;
    int e0, r0, u0;
    rst = 1'b1;
    spi_sclk = 1'b1;
    spi_mosi = 1'b0;
    tx16[0] = '0; tx16[1] = '0; tx8 = '0;
    for (int k = 0; k < 3; k++) begin
      csN[k] = 1'b1;
      txValid[k] = 1'b0;
    end
    cpol = 1'b1; cpha = 1'b1; msbf = 1'b1; width = 16;

    repeat (5) @(negedge clk_in);
    checkOutput("rst_miso", 32'(miso[0]), 32'h0);
    checkOutput("rst_oe", 32'(oe[0]), 32'h0);
    checkOutput("rst_tx_ready", 32'(txReady[0]), 32'h1);
    checkOutput("rst_busy", 32'(busy[0]), 32'h0);
    checkOutput("rst_rx_data", 32'(rxData16[0]), 32'h0);
    checkOutput("rst_rx_valid", 32'(rxValid[0]), 32'h0);
    rst = 1'b0;

    // Mode 3 single word
    setMode(1'b1, 1'b1, 1'b1, 16);
    pushTx(0, 16'hA5C3);
    checkOutput("m3_hold_full", 32'(txReady[0]), 32'h0);
    csLow(0);
    checkOutput("m3_busy", 32'(busy[0]), 32'h1);
    checkOutput("m3_oe", 32'(oe[0]), 32'h1);
    checkOutput("m3_no_underrun", 32'(urCount[0]), 32'd0);
    applyStimulus(0, 16, 32'h1234, rd);
    csHigh(0);
    checkOutput("m3_master_rd", rd, 32'hA5C3);
    checkOutput("m3_rx_data", 32'(rxData16[0]), 32'h1234);
    checkOutput("m3_rx_count", 32'(rxCount[0]), 32'd1);
    checkOutput("m3_err_count", 32'(errCount[0]), 32'd0);
    checkOutput("m3_idle_busy", 32'(busy[0]), 32'h0);
    checkOutput("m3_idle_oe", 32'(oe[0]), 32'h0);
    checkOutput("m3_idle_miso", 32'(miso[0]), 32'h0);

    // CS raised after 7 bits
    csLow(0);
    applyStimulus(0, 7, 32'hFFFF, rd);
    csHigh(0);
    checkOutput("ferr_count", 32'(errCount[0]), 32'd1);
    checkOutput("ferr_rx_kept", 32'(rxData16[0]), 32'h1234);
    checkOutput("ferr_rx_count", 32'(rxCount[0]), 32'd1);
    checkOutput("ferr_idle", 32'(busy[0]), 32'h0);

    // Underrun at CS fall
    u0 = urCount[0];
    csLow(0);
    checkOutput("ur_pulse", 32'(urCount[0]), 32'(u0 + 1));
    applyStimulus(0, 16, 32'h5A5A, rd);
    csHigh(0);
    checkOutput("ur_master_rd", rd, 32'h0000);
    checkOutput("ur_rx_data", 32'(rxData16[0]), 32'h5A5A);

    // Mode 0, three words in one frame; a fourth word keeps the final wrap fed
    setMode(1'b0, 1'b0, 1'b1, 16);
    pushTx(1, 16'h1111);
    csLow(1);
    pushTx(1, 16'h2222);
    applyStimulus(1, 16, 32'h0001, rd);
    checkOutput("m0_rd0", rd, 32'h1111);
    pushTx(1, 16'h3333);
    applyStimulus(1, 16, 32'h8000, rd);
    checkOutput("m0_rd1", rd, 32'h2222);
    pushTx(1, 16'h0000);
    applyStimulus(1, 16, 32'hFFFF, rd);
    checkOutput("m0_rd2", rd, 32'h3333);
    csHigh(1);
    checkOutput("m0_rx_count", 32'(rxCount[1]), 32'd3);
    checkOutput("m0_rx0", 32'(rxLog[0]), 32'h0001);
    checkOutput("m0_rx1", 32'(rxLog[1]), 32'h8000);
    checkOutput("m0_rx2", 32'(rxLog[2]), 32'hFFFF);
    checkOutput("m0_underrun", 32'(urCount[1]), 32'd0);
    checkOutput("m0_err", 32'(errCount[1]), 32'd0);

    // 8-bit, LSB first, CPOL=1 CPHA=0
    setMode(1'b1, 1'b0, 1'b0, 8);
    pushTx(2, 16'h00C6);
    csLow(2);
    applyStimulus(2, 8, 32'h01, rd);
    csHigh(2);
    checkOutput("m8_rx_data", 32'(rxData8), 32'h01);
    checkOutput("m8_master_rd", rd, 32'hC6);
    checkOutput("m8_rx_count", 32'(rxCount[2]), 32'd1);
    checkOutput("m8_err", 32'(errCount[2]), 32'd0);

    // Reset at bit 9, then a clean frame
    setMode(1'b1, 1'b1, 1'b1, 16);
    pushTx(0, 16'h0F0F);
    e0 = errCount[0];
    csLow(0);
    applyStimulus(0, 9, 32'hBEEF, rd);
    @(negedge clk_in);
    rst = 1'b1;
    repeat (3) @(negedge clk_in);
    checkOutput("mrst_miso", 32'(miso[0]), 32'h0);
    checkOutput("mrst_oe", 32'(oe[0]), 32'h0);
    checkOutput("mrst_busy", 32'(busy[0]), 32'h0);
    checkOutput("mrst_rx_data", 32'(rxData16[0]), 32'h0);
    checkOutput("mrst_tx_ready", 32'(txReady[0]), 32'h1);
    checkOutput("mrst_rx_valid", 32'(rxValid[0]), 32'h0);
    csN[0] = 1'b1;
    repeat (6) @(negedge clk_in);
    rst = 1'b0;
    repeat (10) @(negedge clk_in);
    checkOutput("mrst_stays_idle", 32'(busy[0]), 32'h0);
    checkOutput("mrst_no_ferr", 32'(errCount[0]), 32'(e0));
    r0 = rxCount[0];
    pushTx(0, 16'h0F0F);
    csLow(0);
    applyStimulus(0, 16, 32'hBEEF, rd);
    csHigh(0);
    checkOutput("mrst_master_rd", rd, 32'h0F0F);
    checkOutput("mrst_rx_data_new", 32'(rxData16[0]), 32'hBEEF);
    checkOutput("mrst_rx_count", 32'(rxCount[0]), 32'(r0 + 1));
    checkOutput("mrst_err_after", 32'(errCount[0]), 32'(e0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
